// File: rtl/pipelined_controller.sv
// pipelined_controller: MIPS ID decode and control pipeline with load-use, SPECIAL2 multi-cycle and branch-flush handling
module pipelined_controller #(
  parameter int ALUOP_W = 5,
  parameter int BJ_W = 3,
  parameter int RA_W = 5,
  parameter int MADD_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               branch_flush,
  output logic               stall,
  output logic               ex_alu_source,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BJ_W-1:0]    mem_branch_jump,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic [RA_W-1:0]    wb_dest
);
  localparam int CW = $clog2(MADD_LAT + 1);
  typedef enum logic {IDLE, MBUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic d_vld, d_regdst, d_src, d_m2r, d_rw, d_mr, d_mw, d_sp2, d_rt;
  logic [BJ_W-1:0] d_bj;
  logic [ALUOP_W-1:0] d_op;
  logic [RA_W-1:0] d_dest;
  logic ex_m2r, ex_rw, ex_mr, ex_mw, ex_sp2;
  logic [BJ_W-1:0] ex_bj;
  logic [RA_W-1:0] ex_dest;
  logic m_m2r, m_rw;
  logic [RA_W-1:0] m_dest;
  logic lu, busy, load, start;
  always_comb begin
    {d_vld, d_regdst, d_src, d_m2r, d_rw, d_mr, d_mw, d_sp2, d_rt} = 9'b100000000;
    d_bj = '0;
    d_op = '0;
    case (opcode)
      6'h00: {d_m2r, d_rw, d_rt} = 3'b111;
      6'h08: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(2); end
      6'h09: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(7); end
      6'h0a: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(5); end
      6'h0b: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(9); end
      6'h0c: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(1); end
      6'h0d: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(3); end
      6'h0e: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(4); end
      6'h0f: begin {d_regdst, d_src, d_m2r, d_rw} = 4'hf; d_op = ALUOP_W'(10); end
      6'h1c: begin {d_m2r, d_rw, d_rt, d_sp2} = 4'hf; d_op = ALUOP_W'(8); end
      6'h20, 6'h21, 6'h23: begin {d_regdst, d_src, d_rw, d_mr} = 4'hf; d_op = ALUOP_W'(2); end
      6'h28, 6'h29, 6'h2b: begin {d_src, d_mw, d_rt} = 3'b111; d_op = ALUOP_W'(2); end
      6'h04: begin d_bj = BJ_W'(1); d_op = ALUOP_W'(6); d_rt = 1'b1; end
      6'h05: begin d_bj = BJ_W'(2); d_op = ALUOP_W'(6); d_rt = 1'b1; end
      6'h01: begin d_bj = BJ_W'(4); d_op = ALUOP_W'(6); end
      6'h07: begin d_bj = BJ_W'(5); d_op = ALUOP_W'(6); end
      6'h06: begin d_bj = BJ_W'(6); d_op = ALUOP_W'(6); end
      6'h02: d_bj = BJ_W'(3);
      6'h03: begin d_bj = BJ_W'(7); {d_m2r, d_rw} = 2'b11; end
      default: d_vld = 1'b0;
    endcase
  end
  assign d_dest = !d_vld ? '0 : opcode == 6'h03 ? RA_W'(31) : d_regdst ? id_rt : id_rd;
  assign lu = ex_mr && ex_dest != '0 && (ex_dest == id_rs || (ex_dest == id_rt && d_rt));
  assign busy = state == MBUSY && cnt != '0;
  assign stall = !branch_flush && (busy || lu);
  assign load = !branch_flush && !busy && !lu;
  assign start = load && d_sp2 && MADD_LAT > 1;
  always_comb begin
    state_nx = (busy && !branch_flush) || start ? MBUSY : IDLE;
    cnt_nx = busy && !branch_flush ? cnt - CW'(1) : start ? CW'(MADD_LAT - 1) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {ex_alu_source, ex_alu_op, ex_mr, ex_mw, ex_bj, ex_rw, ex_m2r, ex_dest, ex_sp2} <= '0;
      {mem_read, mem_write, mem_branch_jump, m_rw, m_m2r, m_dest} <= '0;
      {wb_reg_write, wb_mem_to_reg, wb_dest} <= '0;
    end else begin
      if (!busy || branch_flush)
        {ex_alu_source, ex_alu_op, ex_mr, ex_mw, ex_bj, ex_rw, ex_m2r, ex_dest, ex_sp2} <=
          load ? {d_src, d_op, d_mr, d_mw, d_bj, d_rw, d_m2r, d_dest, d_sp2} : '0;
      {mem_read, mem_write, mem_branch_jump, m_rw, m_m2r, m_dest} <=
        branch_flush || busy ? '0 : {ex_mr, ex_mw, ex_bj, ex_rw, ex_m2r, ex_dest};
      {wb_reg_write, wb_mem_to_reg, wb_dest} <= {m_rw, m_m2r, m_dest};
    end
  end
endmodule
